// File: rtl/comparator_bias_ctrl.sv
// Comparator bias sequencer: settles the bias generator, then issues strobed comparator samples.
// Optional bias duty-cycling when idle is enabled by defining COMP_BIAS_DUTY_CYCLE_EN.
module comparator_bias_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned IDLE_CYCLES   = 128
) (
    input  logic       wb_clk_i,
    input  logic       porb,
    input  logic       en,
    input  logic [3:0] trim_in,
    input  logic       trim_load,
    input  logic       sample_req,
    input  logic       comp_out,
    output logic       bias_en,
    output logic [3:0] bias_trim,
    output logic       bias_ready,
    output logic       comp_strobe,
    output logic       sample_valid,
    output logic       sample_bit
);

`ifdef COMP_BIAS_DUTY_CYCLE_EN
    typedef enum logic [2:0] {StOff, StSettle, StReady, StStrobe, StSleep} state_e;
    localparam logic [7:0] IdleLast = 8'(IDLE_CYCLES - 1);
    logic [7:0] idle_q, idle_d;
`else
    typedef enum logic [1:0] {StOff, StSettle, StReady, StStrobe} state_e;
`endif

    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] StrobeLoad = 8'(STROBE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
`ifdef COMP_BIAS_DUTY_CYCLE_EN
        idle_d  = '0;
`endif
        if (!en) begin
            state_d = StOff;
            cnt_d   = '0;
        end else if (trim_load &&
                     (state_q == StSettle || state_q == StReady || state_q == StStrobe)) begin
            // A new trim code invalidates the settled bias; any strobe in flight is dropped.
            state_d = StSettle;
            cnt_d   = SettleLoad;
        end else begin
            case (state_q)
                StOff: begin
                    state_d = StSettle;
                    cnt_d   = SettleLoad;
                end
                StSettle: begin
                    if (cnt_q == '0) state_d = StReady;
                    else             cnt_d   = cnt_q - 8'd1;
                end
                StReady: begin
                    if (sample_req) begin
                        state_d = StStrobe;
                        cnt_d   = StrobeLoad;
                    end
`ifdef COMP_BIAS_DUTY_CYCLE_EN
                    else if (idle_q == IdleLast) state_d = StSleep;
                    else                         idle_d  = idle_q + 8'd1;
`endif
                end
                StStrobe: begin
                    if (cnt_q == '0) begin
                        state_d = StReady;
                        capture = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
`ifdef COMP_BIAS_DUTY_CYCLE_EN
                StSleep: begin
                    if (sample_req) begin
                        state_d = StSettle;
                        cnt_d   = SettleLoad;
                    end
                end
`endif
                default: begin
                    state_d = StOff;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge wb_clk_i or negedge porb) begin
        if (!porb) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            bias_en      <= 1'b0;
            bias_trim    <= 4'b1000;
            bias_ready   <= 1'b0;
            comp_strobe  <= 1'b0;
            sample_valid <= 1'b0;
            sample_bit   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bias_en      <= (state_d == StSettle) || (state_d == StReady) ||
                            (state_d == StStrobe);
            bias_ready   <= (state_d == StReady) || (state_d == StStrobe);
            comp_strobe  <= (state_d == StStrobe);
            sample_valid <= capture;
            if (trim_load) bias_trim  <= trim_in;
            if (capture)   sample_bit <= comp_out;
        end
    end

`ifdef COMP_BIAS_DUTY_CYCLE_EN
    always_ff @(posedge wb_clk_i or negedge porb) begin
        if (!porb) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`endif

endmodule

// File: tb/tb_comparator_bias_ctrl.sv
// Randomized self-checking bench for comparator_bias_ctrl against a cycle-level behavioural model.
// Honours COMP_BIAS_DUTY_CYCLE_EN when the design is built with it.
module tb_comparator_bias_ctrl;

    localparam int SETTLE = 4;
    localparam int STROBE = 2;
    localparam int IDLE   = 8;

    logic       wb_clk_i   = 1'b0;
    logic       porb       = 1'b1;
    logic       en         = 1'b0;
    logic [3:0] trim_in    = 4'h0;
    logic       trim_load  = 1'b0;
    logic       sample_req = 1'b0;
    logic       comp_out   = 1'b0;
    logic       bias_en, bias_ready, comp_strobe, sample_valid, sample_bit;
    logic [3:0] bias_trim;

    int n_checks = 0;
    int n_errors = 0;

    // Model: bias on/asleep flags plus clocks elapsed in the settle and strobe phases.
    bit         m_on, m_asleep, m_valid, m_bit;
    int         m_settled, m_strobe, m_idle;
    logic [3:0] m_trim;

    always #5 wb_clk_i = ~wb_clk_i;

    comparator_bias_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .STROBE_CYCLES(STROBE),
        .IDLE_CYCLES  (IDLE)
    ) u_dut (
        .wb_clk_i    (wb_clk_i),
        .porb        (porb),
        .en          (en),
        .trim_in     (trim_in),
        .trim_load   (trim_load),
        .sample_req  (sample_req),
        .comp_out    (comp_out),
        .bias_en     (bias_en),
        .bias_trim   (bias_trim),
        .bias_ready  (bias_ready),
        .comp_strobe (comp_strobe),
        .sample_valid(sample_valid),
        .sample_bit  (sample_bit)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_asleep = 0; m_valid = 0; m_bit = 0;
        m_settled = 0; m_strobe = 0; m_idle = 0;
        m_trim = 4'b1000;
    endtask

    task automatic model_edge();
        m_valid = 0;
        if (trim_load) m_trim = trim_in;
        if (!en) begin
            m_on = 0; m_asleep = 0; m_settled = 0; m_strobe = 0; m_idle = 0;
        end else if (m_asleep) begin
            if (sample_req) begin
                m_asleep = 0; m_on = 1; m_settled = 0;
            end
        end else if (!m_on) begin
            m_on = 1; m_settled = 0; m_strobe = 0; m_idle = 0;
        end else if (trim_load) begin
            m_settled = 0; m_strobe = 0; m_idle = 0;
        end else if (m_settled < SETTLE) begin
            m_settled++;
        end else if (m_strobe > 0) begin
            if (m_strobe == STROBE) begin
                m_bit = comp_out; m_valid = 1; m_strobe = 0;
            end else begin
                m_strobe++;
            end
        end else if (sample_req) begin
            m_strobe = 1; m_idle = 0;
        end else begin
`ifdef COMP_BIAS_DUTY_CYCLE_EN
            m_idle++;
            if (m_idle == IDLE) begin
                m_on = 0; m_asleep = 1; m_idle = 0;
            end
`endif
        end
    endtask

    task automatic check_outputs();
        check_eq("bias_en",      32'(bias_en),      32'(m_on));
        check_eq("bias_trim",    32'(bias_trim),    32'(m_trim));
        check_eq("bias_ready",   32'(bias_ready),   32'(m_on && (m_settled == SETTLE)));
        check_eq("comp_strobe",  32'(comp_strobe),  32'(m_strobe > 0));
        check_eq("sample_valid", 32'(sample_valid), 32'(m_valid));
        check_eq("sample_bit",   32'(sample_bit),   32'(m_bit));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        @(posedge wb_clk_i);
        model_edge();
        #1;
        check_outputs();
        @(negedge wb_clk_i);
    endtask

    task automatic pulse_reset();
        #2 porb = 1'b0;
        #1 model_reset();
        check_outputs();
        check_eq("rst_trim", 32'(bias_trim), 32'h8);
        @(negedge wb_clk_i);
        porb = 1'b1;
    endtask

    initial begin
        int t_en, t_rdy, lat;
        pulse_reset();
        for (int i = 0; i < 3; i++) step();

        // Settle latency: bias_ready follows bias_en by SETTLE clocks.
        en = 1'b1;
        t_en = -1; t_rdy = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bias_en && t_en < 0) t_en = i;
            if (bias_ready && t_rdy < 0) t_rdy = i;
            if (t_rdy >= 0) break;
        end
        check_eq("bias_en_lat", 32'(t_en), 32'd0);
        check_eq("settle_len", 32'(t_rdy - t_en), 32'(SETTLE));

        // Sample latency: request to sample_valid is STROBE+1 clocks.
        sample_req = 1'b1; comp_out = 1'b1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sample_valid) begin
                lat = i + 1;
                break;
            end
        end
        check_eq("sample_lat", 32'(lat), 32'(STROBE + 1));
        check_eq("sample_one", 32'(sample_bit), 32'd1);

        // Asynchronous reset in the middle of a strobe.
        comp_out = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (comp_strobe) break;
        end
        check_eq("strobe_seen", 32'(comp_strobe), 32'd1);
        sample_req = 1'b0;
        pulse_reset();

        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 99) < 97);
            trim_load = ($urandom_range(0, 99) < 4);
            trim_in   = 4'($urandom);
            comp_out  = 1'($urandom);
            if (sample_valid && $urandom_range(0, 1) == 0) sample_req = 1'b0;
            else if ($urandom_range(0, 7) == 0)              sample_req = ~sample_req;
            if ($urandom_range(0, 499) == 0) pulse_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
